aes_round_engine: RTL and testbench

//  Iterative AES-128 encryption core for rounds 1..10. Takes the 128-bit state that the

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_round_engine_round.sv | 38 +++
 rtl/aes_round_engine.sv | 83 ++++++++
 tb/tb_aes_round_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box table, round count, GF(2^8) helper,
// engine FSM encoding and round-key extraction from the expanded key.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round key r sits at the top of the expanded key for r = 0.
  function automatic logic [127:0] round_key(input logic [1407:0] ek, input logic [3:0] r);
    logic [1407:0] shifted;
    shifted = ek << (128 * int'(r));
    return shifted[1407 -: 128];
  endfunction

endpackage

// File: rtl/aes_round_engine_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic         final_rnd,
  output logic [127:0] next_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte k is row k%4, column k/4; byte 0 occupies the top bits.
  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      sb[k] = SBOX[state[127 - 8*k -: 8]];
    end
    // Row r rotates left by r columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    next_state = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      next_state[127 - 8*k -: 8] = (final_rnd ? sr[k] : mc[k]) ^ rkey[127 - 8*k -: 8];
    end
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 engine for rounds 1..10, one round per clock,
// with valid/ready handshakes on both sides.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned NR    = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       state_in,
  input  logic [1407:0]      expandedKey,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       cypherText,
  output logic               busy,
  output logic [CNT_W-1:0]   round_idx
);

  fsm_t             fsm;
  logic [CNT_W-1:0] rnd;
  logic [127:0]     st;
  logic [127:0]     rkey;
  logic [127:0]     rnd_out;

  assign rkey = round_key(expandedKey, rnd);

  aes_round u_round (
    .state      (st),
    .rkey       (rkey),
    .final_rnd  (fsm == FINAL),
    .next_state (rnd_out)
  );

  // FSM, round counter and state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      rnd <= '0;
      st  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st  <= state_in;
            rnd <= CNT_W'(1);
            fsm <= ROUND;
          end
        end
        ROUND: begin
          st  <= rnd_out;
          rnd <= rnd + 1'b1;
          if (rnd == CNT_W'(NR - 1)) begin
            fsm <= FINAL;
          end
        end
        FINAL: begin
          st  <= rnd_out;
          rnd <= '0;
          fsm <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Status and output decode; ciphertext only exposed while valid.
  always_comb begin
    in_ready   = (fsm == IDLE);
    out_valid  = (fsm == DONE);
    busy       = (fsm == ROUND) || (fsm == FINAL);
    round_idx  = busy ? rnd : '0;
    cypherText = out_valid ? st : '0;
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine using FIPS-197 vectors.
module tb_aes_round_engine;
  import aes_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  state_in;
  logic [1407:0] ek;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  cypherText;
  logic          busy;
  logic [3:0]    round_idx;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IN_C1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_round_engine #(.NR(10), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
    .expandedKey (ek),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cypherText  (cypherText),
    .busy        (busy),
    .round_idx   (round_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407 - 32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; walks rounds until out_valid (bounded).
  task automatic run_block(input string tag, input logic [127:0] exp);
    int n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      check({tag, "_ridx"}, round_idx, n + 1);
      check({tag, "_busy"}, busy, 1'b1);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 10);
    check({tag, "_ct"}, cypherText, exp);
    check({tag, "_done_rdy"}, in_ready, 1'b0);
    check({tag, "_done_ridx"}, round_idx, 0);
  endtask

  task automatic accept(input string tag, input logic [127:0] key, input logic [127:0] sin);
    ek       = expand(key);
    state_in = sin;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
  endtask

  initial begin
    int last_acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_in  = '0;
    ek        = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ridx", round_idx, 0);
    check("rst_ct", cypherText, '0);

    // FIPS-197 C.1, output consumed immediately
    accept("c1", KEY_C1, IN_C1);
    in_valid = 1'b0;
    run_block("c1", CT_C1);
    tick();
    check("c1_post_ready", in_ready, 1'b1);
    check("c1_post_valid", out_valid, 1'b0);

    // FIPS-197 App.B with back-pressure and ignored input pulses
    out_ready = 1'b0;
    accept("appb", KEY_B, PT_B ^ KEY_B);
    in_valid = 1'b0;
    run_block("appb", CT_B);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      state_in = {4{$urandom}};
      tick();
      check("bp_valid", out_valid, 1'b1);
      check("bp_ct", cypherText, CT_B);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_ready", in_ready, 1'b1);
    check("bp_rel_busy", busy, 1'b0);

    // Reset while applying round 4, then a clean C.1 block
    accept("rst_mid", KEY_C1, IN_C1);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_ridx", round_idx, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_in_ready", in_ready, 1'b1);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_ridx0", round_idx, 0);
    check("mid_busy", busy, 1'b0);
    accept("c1b", KEY_C1, IN_C1);
    in_valid = 1'b0;
    run_block("c1b", CT_C1);
    tick();

    // Back-to-back with in_valid and out_ready held high:
    // 10 round cycles + DONE handshake cycle + IDLE cycle between accepts
    last_acc = 0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) check("b2b_spacing", cyc - last_acc, 12);
      last_acc = cyc;
      if (b == 1) begin
        accept("b2b", KEY_B, PT_B ^ KEY_B);
        run_block("b2b", CT_B);
      end else begin
        accept("b2b", KEY_C1, IN_C1);
        run_block("b2b", CT_C1);
      end
      tick();
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
